uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
UART receive front end: oversamples the serial RX pin, reassembles 8N1 frames and buffers the bytes in a small first-word-fall-through FIFO. It sits directly upstream of the peripheral block's UART receive register and RX interrupt. The peripheral pops bytes on CPU reads of the UART data address and uses rx_irq as its RX interrupt source.

Parameters:
CLK_HZ, 50000000, sysclk frequency in Hz
BAUD, 9600, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer, >= 4)
FIFO_DEPTH, 4, byte entries; power of two, >= 2

Ports:
sysclk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input, idle high
rd_en  in  1  pop head byte; ignored when rx_valid=0
clr_err  in  1  one-cycle pulse clearing frame_err and overrun
rx_data  out  8  FIFO head byte; 0 when empty
rx_valid  out  1  FIFO non-empty
rx_irq  out  1  equal to rx_valid (level interrupt)
frame_err  out  1  sticky: stop bit sampled low
overrun  out  1  sticky: byte dropped because FIFO full
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy

Behaviour:
- Reset: synchronous on sysclk while reset=1. State IDLE; counters 0; FIFO empty; rx_data=0, rx_valid=0, rx_irq=0, frame_err=0, overrun=0, fifo_count=0. Synchronizer flops preset to 1. Reset mid-frame discards the partial byte.
- Synchronizer: rx goes through two flops to give rx_s. A pin change is visible on rx_s 2 cycles later.
- HALF = CLKS_PER_BIT/2 (floor).
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s=0 -> START, cnt=0.
  - START: counts to HALF-1, then samples rx_s. If rx_s=0 -> DATA, bit_idx=0, cnt=0. If rx_s=1 (glitch) -> IDLE, nothing pushed.
  - DATA: samples rx_s every CLKS_PER_BIT cycles into the shift register, LSB first. After the 8th sample -> STOP.
  - STOP: samples rx_s after CLKS_PER_BIT cycles. If rx_s=1, pushes the byte and goes to IDLE on the same edge. If rx_s=0, sets frame_err, discards the byte and goes to BREAK.
  - BREAK: waits for rx_s=1, then goes to IDLE (no start detection while the line is held low).
- Timing: with rx_s falling at cycle t0:
  - start is sampled at t0+HALF;
  - data bit k (k = 0..7) is sampled at t0+HALF+(k+1)*CLKS_PER_BIT;
  - stop is sampled at t0+HALF+9*CLKS_PER_BIT;
  - the push is registered at that edge, so rx_valid is high on the following cycle.
- FIFO: first-word-fall-through. rx_data shows the head combinationally from the registered storage. rd_en with rx_valid=1 pops at the clock edge. Pointers wrap modulo FIFO_DEPTH.
- Push while full:
  - with no pop in the same cycle, the byte is dropped and overrun is set;
  - with a pop in the same cycle, the push is accepted, the count is unchanged and overrun is not set.
- Pop while empty: no effect.
- Simultaneous push and pop when not full: count unchanged.
- Sticky flags: clr_err clears both frame_err and overrun. If a set event and clr_err occur in the same cycle, set wins.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, BREAK);
  - function clks_per_bit(CLK_HZ, BAUD);
  - constant DATA_BITS = 8.
- Sub-module byte_fifo, parameterised by DEPTH: push/pop/full/empty/count, FWFT output. The top module holds the synchronizer, FSM, baud counter and sticky flags.

Test Plan:
All scenarios use CLK_HZ=16, BAUD=1 (CLKS_PER_BIT=16, HALF=8), rd_en=0 unless stated.
1. Clean frame: drive 0x55 8N1 with the rx pin falling at cycle p -> rx_valid=1 and rx_data=0x55 first seen at cycle p+2+8+144+1=p+155, fifo_count=1, frame_err=0. Pulse rd_en -> rx_valid=0, rx_data=0.
2. Start glitch: rx low for 4 cycles then high -> FSM returns to IDLE, no push. A following valid 0xC3 frame is received correctly.
3. Framing error: frame 0xA3 with stop bit held low for 40 cycles -> frame_err=1, fifo_count=0, no new start detected until rx high. Pulse clr_err -> frame_err=0.
4. Overrun: send bytes 0x01..0x05 back-to-back with no reads -> fifo_count=4, overrun=1. Four pops return 0x01, 0x02, 0x03, 0x04, then rx_valid=0.
5. Pop on push when full: FIFO holds 0x11..0x14, assert rd_en exactly on the stop-sample cycle of 0x15 -> no overrun, count stays 4, subsequent pops return 0x12, 0x13, 0x14, 0x15.
6. Reset mid-frame: assert reset for 1 cycle during data bit 4 of 0x7E -> all outputs 0, no push. The next 0x81 frame yields rx_data=0x81, fifo_count=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Integer number of sysclk cycles per bit time.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small first-word-fall-through byte FIFO. The head is driven combinationally
// from registered storage. A push while full is accepted only when a pop
// frees a slot on the same edge.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];
  assign count   = cnt;

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracks both.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with mid-bit sampling, sticky error flags and an
// FWFT byte FIFO feeding the peripheral's receive register and interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  output logic                          rx_irq,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int BW   = $clog2(DATA_BITS);

  logic                 rx_m, rx_s;
  rx_state_t            state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [BW-1:0]        bit_idx, bit_d;
  logic [DATA_BITS-1:0] shreg, sh_d;
  logic                 push, ferr_set, ovr_set;
  logic                 fifo_full, fifo_empty;

  // Two-flop synchronizer, preset to the idle line level.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receiver state, baud counter, bit index and shift register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shreg   <= sh_d;
    end
  end

  // Next-state: half-bit start qualification, then full-bit sampling.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bit_d    = bit_idx;
    sh_d     = shreg;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == CW'(HALF-1)) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CW'(CPB-1)) begin
          cnt_d = '0;
          sh_d  = {rx_s, shreg[DATA_BITS-1:1]};
          if (bit_idx == BW'(DATA_BITS-1)) state_d = STOP;
          else                             bit_d   = bit_idx + BW'(1);
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CW'(CPB-1)) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = BREAK;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO drops the byte unless a pop frees a slot on the same edge.
  assign ovr_set = push && fifo_full && !(rd_en && rx_valid);

  // Sticky error flags; a set event outranks a same-cycle clear.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set | (frame_err & ~clr_err);
      overrun   <= ovr_set  | (overrun   & ~clr_err);
    end
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (push),
    .pop    (rd_en),
    .din    (shreg),
    .dout   (rx_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign rx_valid = !fifo_empty;
  assign rx_irq   = rx_valid;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit.
module tb_uart_rx_fifo;
  logic       sysclk = 1'b0;
  logic       reset = 1'b1, rx = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_irq, frame_err, overrun;
  logic [2:0] fifo_count;
  int         cyc = 0;
  int         pass_cnt = 0, tot_cnt = 0;
  int         p;

  typedef struct {
    logic [7:0] d;
    logic       stop_bit;
    int         stop_len;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_cnt;
    logic       exp_ferr;
  } vec_t;
  vec_t vt[4];

  uart_rx_fifo #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(4)) dut (
    .sysclk(sysclk), .reset(reset), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_irq(rx_irq),
    .frame_err(frame_err), .overrun(overrun), .fifo_count(fifo_count)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge sysclk); #1; end
  endtask

  // Drives one 8N1 frame, one bit per 16 cycles; stops early at cycle 'cut'.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int stop_len, input int cut);
    for (int i = 0; i < 144 + stop_len; i++) begin
      if (i >= cut) break;
      if (i < 16)       rx = 1'b0;
      else if (i < 144) rx = d[(i-16)/16];
      else              rx = stop_bit;
      tick(1);
    end
    rx = 1'b1;
  endtask

  task automatic status(input string tag, input logic v, input logic [7:0] d,
                        input logic [2:0] c, input logic fe, input logic ov);
    @(negedge sysclk);
    check({tag, ".valid"}, rx_valid, v);
    check({tag, ".irq"},   rx_irq, v);
    check({tag, ".data"},  rx_data, d);
    check({tag, ".count"}, fifo_count, c);
    check({tag, ".ferr"},  frame_err, fe);
    check({tag, ".ovr"},   overrun, ov);
    @(posedge sysclk); #1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    @(negedge sysclk);
    check({tag, ".pop_valid"}, rx_valid, 1'b1);
    check({tag, ".pop_data"},  rx_data, exp);
    @(posedge sysclk); #1;
    rd_en = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  initial begin
    vt[0] = '{8'h00, 1'b1, 16, 1'b1, 8'h00, 3'd1, 1'b0};
    vt[1] = '{8'hFF, 1'b1, 16, 1'b1, 8'hFF, 3'd1, 1'b0};
    vt[2] = '{8'h3C, 1'b1, 16, 1'b1, 8'h3C, 3'd1, 1'b0};
    vt[3] = '{8'hA3, 1'b0, 40, 1'b0, 8'h00, 3'd0, 1'b1};

    tick(3);
    status("reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(2);

    // Clean frame with exact first-valid cycle
    p = cyc;
    fork
      send_frame(8'h55, 1'b1, 16, 999);
      begin
        while (cyc != p + 154) @(negedge sysclk);
        check("t1.valid_before", rx_valid, 1'b0);
        @(negedge sysclk);
        check("t1.valid_at155", rx_valid, 1'b1);
        check("t1.data", rx_data, 8'h55);
        check("t1.count", fifo_count, 3'd1);
        check("t1.ferr", frame_err, 1'b0);
      end
    join
    pop_check("t1", 8'h55);
    status("t1.after_pop", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Table of single frames
    for (int i = 0; i < 4; i++) begin
      send_frame(vt[i].d, vt[i].stop_bit, vt[i].stop_len, 999);
      tick(4);
      status($sformatf("vec%0d", i), vt[i].exp_valid, vt[i].exp_data,
             vt[i].exp_cnt, vt[i].exp_ferr, 1'b0);
      if (vt[i].exp_valid) pop_check($sformatf("vec%0d", i), vt[i].exp_data);
      if (vt[i].exp_ferr) clr_pulse();
      status($sformatf("vec%0d.clear", i), 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Start glitch, then a valid frame
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(20);
    status("t2.glitch", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 16, 999);
    tick(2);
    status("t2.frame", 1'b1, 8'hC3, 3'd1, 1'b0, 1'b0);
    pop_check("t2", 8'hC3);

    // Framing error with clr_err on the same edge: set must win
    p = cyc;
    fork
      send_frame(8'hA3, 1'b0, 40, 999);
      begin
        while (cyc != p + 154) tick(1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
      end
    join
    tick(4);
    status("t3.ferr", 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    clr_pulse();
    status("t3.clr", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Overrun: five bytes, no reads
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 16, 999);
    tick(2);
    status("t4.full", 1'b1, 8'h01, 3'd4, 1'b0, 1'b1);
    for (int b = 1; b <= 4; b++) pop_check($sformatf("t4.pop%0d", b), 8'(b));
    clr_pulse();
    status("t4.empty", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

    // Pop coinciding with push while full
    for (int b = 8'h11; b <= 8'h14; b++) send_frame(8'(b), 1'b1, 16, 999);
    p = cyc;
    fork
      send_frame(8'h15, 1'b1, 16, 999);
      begin
        while (cyc != p + 154) tick(1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
      end
    join
    tick(2);
    status("t5.full", 1'b1, 8'h12, 3'd4, 1'b0, 1'b0);
    pop_check("t5.a", 8'h12);
    pop_check("t5.b", 8'h13);
    pop_check("t5.c", 8'h14);
    status("t5.head", 1'b1, 8'h15, 3'd1, 1'b0, 1'b0);

    // Reset during data bit 4 clears FIFO and discards partial byte
    p = cyc;
    fork
      send_frame(8'h7E, 1'b1, 16, 85);
      begin
        while (cyc != p + 84) tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
    join
    status("t6.reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick(200);
    status("t6.nopush", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 16, 999);
    tick(2);
    status("t6.frame", 1'b1, 8'h81, 3'd1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
